// File: rtl/counter_preset_ctrl_if.sv
// rtl/counter_preset_ctrl_if.sv - link between counter_preset_ctrl and the downstream counter_preset
interface counter_preset_ctrl_if #(
    parameter int WIDTH = 4
) ();
    logic             load;
    logic [WIDTH-1:0] data_preset;
    logic             count_up;
    logic             carry_in;

    // Controller side drives the counter commands and watches its carry.
    modport master (
        output load,
        output data_preset,
        output count_up,
        input  carry_in
    );

    // Counter side obeys the commands and reports its carry.
    modport slave (
        input  load,
        input  data_preset,
        input  count_up,
        output carry_in
    );
endinterface

// File: rtl/counter_preset_ctrl.sv
// rtl/counter_preset_ctrl.sv - IDLE/LOAD/RUN controller for counter_preset; optional CTRL_PRESCALE_EN prescaler
module counter_preset_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  hold,
    input  logic                  auto_reload,
    input  logic [WIDTH-1:0]      period_in,
`ifdef CTRL_PRESCALE_EN
    input  logic [3:0]            presc,
`endif
    counter_preset_ctrl_if.master cnt_if,
    output logic                  busy,
    output logic                  tick,
    output logic [7:0]            period_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] preset_q;
    logic             tick_q;
    logic [7:0]       period_cnt_q;
    logic             load_c;
    logic             count_up_c;
    logic             terminal;
    logic             start_acc;

`ifdef CTRL_PRESCALE_EN
    logic [3:0]       psc_q;
`endif

    // stop always wins; an accepted start restarts from any state
    assign start_acc = start && !stop;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and counter commands
    always_comb begin
        state_nxt = state;
        load_c    = (state == LOAD);
`ifdef CTRL_PRESCALE_EN
        count_up_c = (state == RUN) && !hold && (psc_q == presc);
`else
        count_up_c = (state == RUN) && !hold;
`endif
        // carry_in only matters when we are actually asking the counter to step
        terminal  = (state == RUN) && count_up_c && cnt_if.carry_in;

        case (state)
            IDLE:    state_nxt = IDLE;
            LOAD:    state_nxt = RUN;
            RUN: begin
                if (terminal) begin
                    state_nxt = auto_reload ? LOAD : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (start_acc) begin
            state_nxt = LOAD;
        end
        if (stop) begin
            state_nxt = IDLE;
        end
    end

    // Preset capture, registered tick and completed-period counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            preset_q     <= '0;
            tick_q       <= 1'b0;
            period_cnt_q <= 8'd0;
        end else begin
            tick_q <= terminal;
            if (start_acc) begin
                preset_q <= period_in;
            end
            // a restart while already running keeps the period history
            if (start_acc && (state == IDLE)) begin
                period_cnt_q <= 8'd0;
            end else if (terminal) begin
                period_cnt_q <= period_cnt_q + 8'd1;
            end
        end
    end

`ifdef CTRL_PRESCALE_EN
    // Prescaler: restarts on every load, frozen while holding or outside RUN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            psc_q <= 4'd0;
        end else if (state == LOAD) begin
            psc_q <= 4'd0;
        end else if ((state == RUN) && !hold) begin
            psc_q <= (psc_q == presc) ? 4'd0 : psc_q + 4'd1;
        end
    end
`endif

    assign cnt_if.load        = load_c;
    assign cnt_if.count_up    = count_up_c;
    assign cnt_if.data_preset = preset_q;
    assign busy               = (state != IDLE);
    assign tick               = tick_q;
    assign period_cnt         = period_cnt_q;

endmodule

// File: tb/tb_counter_preset_ctrl.sv
// tb/tb_counter_preset_ctrl.sv - directed scoreboard bench for counter_preset_ctrl
module tb_counter_preset_ctrl;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic             hold;
    logic             auto_reload;
    logic [WIDTH-1:0] period_in;
    logic [3:0]       presc;
    logic             busy;
    logic             tick;
    logic [7:0]       period_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [7:0] pcnt;
    } exp_t;

    exp_t sb[$];

    counter_preset_ctrl_if #(.WIDTH(WIDTH)) link ();

    counter_preset_ctrl #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .hold        (hold),
        .auto_reload (auto_reload),
        .period_in   (period_in),
`ifdef CTRL_PRESCALE_EN
        .presc       (presc),
`endif
        .cnt_if      (link.master),
        .busy        (busy),
        .tick        (tick),
        .period_cnt  (period_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference counter_preset: load wins, otherwise step on count_up
    logic [WIDTH-1:0] cnt = '0;
    always @(posedge clk) begin
        if (link.load) cnt <= link.data_preset;
        else if (link.count_up) cnt <= cnt + 1'b1;
    end
    assign link.carry_in = link.count_up && (cnt == {WIDTH{1'b1}});

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Tick monitor: every cycle, tick must match whether the scoreboard expects one now
    always @(negedge clk) begin
        logic exp_tick;
        exp_tick = (sb.size() > 0) && (sb[0].cyc == cyc);
        check("tick", {31'd0, tick}, {31'd0, exp_tick});
        if (exp_tick) begin
            check("tick_period_cnt", {24'd0, period_cnt}, {24'd0, sb[0].pcnt});
            void'(sb.pop_front());
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic oneshot_12(input string tag);
        int k;
        int n_up;
        int n_carry;
        @(negedge clk);
        k = cyc;
        period_in   = 4'd12;
        auto_reload = 1'b0;
        start       = 1'b1;
        sb.push_back('{k + 6, 8'd1});
        @(negedge clk);
        start = 1'b0;
        check({tag, "_load"},        {31'd0, link.load},     32'd1);
        check({tag, "_load_no_up"},  {31'd0, link.count_up}, 32'd0);
        check({tag, "_busy"},        {31'd0, busy},          32'd1);
        check({tag, "_data_preset"}, {28'd0, link.data_preset}, 32'd12);
        n_up = 0;
        n_carry = 0;
        repeat (4) begin
            @(negedge clk);
            n_up    += int'(link.count_up);
            n_carry += int'(link.carry_in);
        end
        check({tag, "_count_up_cycles"}, n_up, 32'd4);
        check({tag, "_carry_last"}, {31'd0, link.carry_in}, 32'd1);
        check({tag, "_carry_once"}, n_carry, 32'd1);
        @(negedge clk);
        check({tag, "_done_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_done_pcnt"},  {24'd0, period_cnt}, 32'd1);
        check({tag, "_done_up"},    {31'd0, link.count_up}, 32'd0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0;
        auto_reload = 1'b0; period_in = '0; presc = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_load",        {31'd0, link.load},        32'd0);
        check("rst_count_up",    {31'd0, link.count_up},    32'd0);
        check("rst_busy",        {31'd0, busy},             32'd0);
        check("rst_data_preset", {28'd0, link.data_preset}, 32'd0);
        check("rst_tick",        {31'd0, tick},             32'd0);
        check("rst_period_cnt",  {24'd0, period_cnt},       32'd0);
        rst_n = 1'b1;

        // One-shot, preset 12
        oneshot_12("oneshot");

        // Periodic, preset 14: period of 3 cycles
        @(negedge clk);
        k = cyc;
        period_in = 4'd14; auto_reload = 1'b1; start = 1'b1;
        for (int i = 0; i < 5; i++) sb.push_back('{k + 4 + 3 * i, 8'(i + 1)});
        @(negedge clk);
        start = 1'b0;
        wait_cyc(k + 16);
        check("periodic_pcnt5",  {24'd0, period_cnt},       32'd5);
        check("periodic_preset", {28'd0, link.data_preset}, 32'd14);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("periodic_stop_busy", {31'd0, busy}, 32'd0);
        repeat (4) @(negedge clk);

        // Hold for 3 cycles mid-run, then stop+start together
        k = cyc;
        period_in = 4'd12; auto_reload = 1'b1; start = 1'b1;
        sb.push_back('{k + 9, 8'd1});
        @(negedge clk);
        start = 1'b0;
        wait_cyc(k + 2);
        check("hold_pre_up", {31'd0, link.count_up}, 32'd1);
        wait_cyc(k + 3);
        hold = 1'b1;
        #1;
        check("hold_up_low", {31'd0, link.count_up}, 32'd0);
        check("hold_busy",   {31'd0, busy},          32'd1);
        wait_cyc(k + 6);
        hold = 1'b0;
        wait_cyc(k + 11);
        stop = 1'b1; start = 1'b1; period_in = 4'd5;
        @(negedge clk);
        stop = 1'b0; start = 1'b0;
        check("abort_busy",   {31'd0, busy},             32'd0);
        check("abort_load",   {31'd0, link.load},        32'd0);
        check("abort_preset", {28'd0, link.data_preset}, 32'd12);
        check("abort_pcnt",   {24'd0, period_cnt},       32'd1);
        repeat (6) @(negedge clk);

        // Restart during RUN with preset 15, then wrap period_cnt
        k = cyc;
        period_in = 4'd14; auto_reload = 1'b1; start = 1'b1;
        sb.push_back('{k + 4, 8'd1});
        @(negedge clk);
        start = 1'b0;
        wait_cyc(k + 5);
        period_in = 4'd15; start = 1'b1;
        for (int i = 0; i < 255; i++) sb.push_back('{k + 8 + 2 * i, 8'(i + 2)});
        @(negedge clk);
        start = 1'b0;
        check("restart_load",   {31'd0, link.load},        32'd1);
        check("restart_preset", {28'd0, link.data_preset}, 32'd15);
        check("restart_pcnt",   {24'd0, period_cnt},       32'd1);
        wait_cyc(k + 516);
        check("wrap_pcnt", {24'd0, period_cnt}, 32'd0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("wrap_stop_busy", {31'd0, busy}, 32'd0);
        repeat (4) @(negedge clk);

        // Reset mid-RUN abandons the period
        k = cyc;
        period_in = 4'd12; auto_reload = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(k + 3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_busy",     {31'd0, busy},             32'd0);
        check("midrst_up",       {31'd0, link.count_up},    32'd0);
        check("midrst_load",     {31'd0, link.load},        32'd0);
        check("midrst_preset",   {28'd0, link.data_preset}, 32'd0);
        check("midrst_tick",     {31'd0, tick},             32'd0);
        check("midrst_pcnt",     {24'd0, period_cnt},       32'd0);
        repeat (6) @(negedge clk);
        oneshot_12("post_rst");

`ifdef CTRL_PRESCALE_EN
        // Prescaled one-shot: presc=2, preset 13
        begin
            int n_up;
            @(negedge clk);
            k = cyc;
            presc = 4'd2; period_in = 4'd13; auto_reload = 1'b0; start = 1'b1;
            sb.push_back('{k + 11, 8'd1});
            @(negedge clk);
            start = 1'b0;
            n_up = 0;
            repeat (9) begin
                @(negedge clk);
                n_up += int'(link.count_up);
                if (cyc == k + 4 || cyc == k + 7 || cyc == k + 10)
                    check("presc_up_on", {31'd0, link.count_up}, 32'd1);
            end
            check("presc_pulses", n_up, 32'd3);
            @(negedge clk);
            check("presc_done_busy", {31'd0, busy}, 32'd0);
        end
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_drain", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_preset_ctrl.md
COUNTER_PRESET_CTRL -- requirements
Module: counter_preset_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits; the same value is used by the downstream counter_preset.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  start/restart command, active high, sampled each edge.
REQ-005 stop  input  1  abort command, active high, priority over start.
REQ-006 hold  input  1  pause counting in RUN, active high.
REQ-007 auto_reload  input  1  1 = periodic mode, 0 = one-shot mode.
REQ-008 period_in  input  WIDTH  preset value, captured on accepted start.
REQ-009 carry_in  input  1  counter_preset carry_out: high while counter is all-ones and count_up is high.
REQ-010 load  output  1  counter_preset load command.
REQ-011 data_preset  output  WIDTH  counter_preset preset data.
REQ-012 count_up  output  1  counter_preset count enable.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 tick  output  1  one-cycle pulse per completed period.
REQ-015 period_cnt  output  8  completed-period count, wraps 255 -> 0.

Function
REQ-016 FSM states SHALL be IDLE, LOAD and RUN; load = (state==LOAD) and is never combined with count_up.
REQ-017 In any state, stop=1 SHALL force next state IDLE; start is ignored in that cycle.
REQ-018 With stop=0 and start=1, in any state: period_in is captured into the preset register, and next state is LOAD; period_cnt is cleared only if the current state is IDLE.
REQ-019 data_preset SHALL always equal the preset register and change only on accepted start.
REQ-020 LOAD SHALL last exactly one cycle and then go to RUN.
REQ-021 In RUN, count_up SHALL be high when hold=0 (subject to REQ-030) and low when hold=1; the state stays RUN while holding.
REQ-022 Terminal event = state RUN, count_up=1 and carry_in=1; carry_in is ignored otherwise.
REQ-023 On a terminal event, next state SHALL be LOAD if auto_reload=1, else IDLE; auto_reload is sampled in the terminal cycle.
REQ-024 tick SHALL be registered: high for exactly one cycle, namely the cycle after each terminal event; period_cnt increments on the same edge.
REQ-025 Periodic-mode period SHALL be (2^WIDTH - preset) + 1 cycles (count cycles plus one LOAD cycle) when hold=0 and no prescaler is used.
REQ-026 A terminal event coincident with start SHALL obey REQ-018 (restart with new value); tick still pulses and period_cnt still increments.

Reset
REQ-027 With rst_n=0 at a clk edge: state=IDLE, preset register=0, tick=0, period_cnt=0, and prescaler=0; consequently load=0, count_up=0, busy=0 and data_preset=0.
REQ-028 Reset mid-operation SHALL abandon the period with no tick; reset has priority over stop and start.

Configuration
REQ-029 Macro CTRL_PRESCALE_EN: when defined, the module adds input presc (4 bits) and an internal 4-bit prescaler.
REQ-030 With the macro defined, count_up in RUN with hold=0 SHALL be high one cycle in every presc+1 cycles, first at the prescaler's terminal; the prescaler is cleared in LOAD and frozen while hold=1; presc=0 gives count_up every cycle.
REQ-031 Without the macro, presc and the prescaler SHALL not exist, and count_up = (state==RUN) && !hold.

Verification (WIDTH=4, macro off unless noted)
REQ-032 One-shot: start pulse with period_in=12 and auto_reload=0 -> load high for 1 cycle, count_up high for 4 cycles, carry_in on the 4th, tick 1 cycle later, busy low, period_cnt=1.
REQ-033 Periodic: period_in=14 and auto_reload=1 -> tick every 3 cycles; period_cnt=5 after 5 periods; data_preset stays 14.
REQ-034 Hold and abort: hold=1 for 3 cycles mid-run -> count_up low and period extended by 3; then stop=1 and start=1 in the same cycle -> IDLE next cycle, no tick, busy=0.
REQ-035 Restart and wrap: start with period_in=15 during RUN -> LOAD next cycle, data_preset=15, periodic period 2 cycles; run 256 periods -> period_cnt wraps to 0.
REQ-036 Reset: rst_n=0 for 1 edge mid-RUN -> all outputs 0 after that edge, no tick; a start applied afterwards behaves as in REQ-032.
REQ-037 Macro on: presc=2, period_in=13, auto_reload=0 -> count_up high every 3rd cycle, 3 pulses total, tick after the 3rd.
